// File: rtl/accum_total_reader.sv
// accum_total_reader
//   Read side of a CNT_W-bit wrapping accumulator. The block counts the
//   accumulator's wrap events in an EXT_W-bit upper word. On request it hands
//   out a coherent {upper, acc_out} snapshot over a valid/ready handshake.
//   The upper word saturates at all-ones and raises a sticky flag.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no snapshot held, rd_valid=0
//   VALID | snapshot held in rd_total/rd_sat, rd_valid=1 until accepted
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   acc_clr   accumulator cleared this cycle; clears upper word and sat
//   acc_vld   acc_out/acc_ovf carry a fresh update this cycle
//   acc_out   accumulator count (lower word of the total)
//   acc_ovf   accumulator carry-out (one wrap)
//   rd_req    snapshot request
//   rd_valid  snapshot available
//   rd_ready  consumer accepts the snapshot
//   rd_total  snapshot {upper, acc_out}
//   rd_sat    upper word was saturated when the snapshot was taken
//   sat       live sticky saturation flag
module accum_total_reader #(
    parameter int CNT_W = 4,
    parameter int EXT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   acc_clr,
    input  logic                   acc_vld,
    input  logic [CNT_W-1:0]       acc_out,
    input  logic                   acc_ovf,
    input  logic                   rd_req,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [CNT_W+EXT_W-1:0] rd_total,
    output logic                   rd_sat,
    output logic                   sat
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] VALID = 1'b1;

    localparam logic [EXT_W-1:0] UPPER_MAX = {EXT_W{1'b1}};

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [EXT_W-1:0] upper;
    logic [EXT_W-1:0] upper_nxt;
    logic             sat_nxt;
    logic             capture;

    // Wrap counter next-state. A clear takes priority over a same-cycle wrap.
    always_comb begin
        upper_nxt = upper;
        sat_nxt   = sat;
        if (acc_clr) begin
            upper_nxt = '0;
            sat_nxt   = 1'b0;
        end else if (acc_vld && acc_ovf) begin
            if (upper != UPPER_MAX) begin
                upper_nxt = upper + 1'b1;
            end else begin
                sat_nxt = 1'b1;
            end
        end
    end

    // In VALID, a new request is accepted only together with the handshake.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    capture   = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (rd_ready) begin
                    if (rd_req) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upper <= '0;
            sat   <= 1'b0;
        end else begin
            upper <= upper_nxt;
            sat   <= sat_nxt;
        end
    end

    // The snapshot uses the post-update upper word so that it pairs correctly
    // with the acc_out presented in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rd_total <= '0;
            rd_sat   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                rd_total <= {upper_nxt, acc_out};
                rd_sat   <= sat_nxt;
            end
        end
    end

    assign rd_valid = (state == VALID);

endmodule

// File: tb/tb_accum_total_reader.sv
module tb_accum_total_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        acc_clr, acc_vld, acc_ovf;
    logic [3:0]  acc_out;
    logic        rd_req, rd_ready;
    logic        rd_valid;
    logic [11:0] rd_total;
    logic        rd_sat;
    logic        sat;

    int n_pass = 0;
    int n_total = 0;

    accum_total_reader #(.CNT_W(4), .EXT_W(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .acc_clr  (acc_clr),
        .acc_vld  (acc_vld),
        .acc_out  (acc_out),
        .acc_ovf  (acc_ovf),
        .rd_req   (rd_req),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_total (rd_total),
        .rd_sat   (rd_sat),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr, vld, ovf;
        logic [3:0]  out;
        logic        req, rdy;
        logic        e_valid;
        logic [11:0] e_total;
        logic        e_rsat, e_sat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic clr, vld, ovf, input logic [3:0] out,
                       input logic req, rdy, input logic ev,
                       input logic [11:0] et, input logic ers, es);
        vec_t v;
        v.clr = clr; v.vld = vld; v.ovf = ovf; v.out = out;
        v.req = req; v.rdy = rdy; v.e_valid = ev; v.e_total = et;
        v.e_rsat = ers; v.e_sat = es;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic clr, vld, ovf, input logic [3:0] out,
                         input logic req, rdy);
        acc_clr = clr; acc_vld = vld; acc_ovf = ovf; acc_out = out;
        rd_req = req; rd_ready = rdy;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 4'h0, 0, 0);

        // T2: three wraps then a request -> 0x035
        for (int i = 0; i < 3; i++) add(0, 1, 1, 4'h0, 0, 0, 0, 12'h000, 0, 0);
        add(0, 0, 0, 4'h5, 1, 0, 1, 12'h035, 0, 0);
        add(0, 0, 0, 4'h5, 0, 1, 0, 12'h035, 0, 0);
        // T3 clear priority: clr with ovf and capture -> {0, acc_out}
        add(1, 1, 1, 4'h7, 1, 0, 1, 12'h007, 0, 0);
        add(0, 0, 0, 4'h7, 0, 1, 0, 12'h007, 0, 0);
        // T3 simultaneous wrap and capture with upper=2 -> 0x031
        add(0, 1, 1, 4'h0, 0, 0, 0, 12'h007, 0, 0);
        add(0, 1, 1, 4'h0, 0, 0, 0, 12'h007, 0, 0);
        add(0, 1, 1, 4'h1, 1, 0, 1, 12'h031, 0, 0);
        // T5: held snapshot stable while wraps continue and rd_req is ignored
        for (int i = 0; i < 5; i++) add(0, 1, 1, 4'h3, 1, 0, 1, 12'h031, 0, 0);
        add(0, 0, 0, 4'h9, 1, 1, 1, 12'h089, 0, 0);
        add(0, 0, 0, 4'h9, 0, 1, 0, 12'h089, 0, 0);
        // T6: acc_ovf without acc_vld is ignored
        for (int i = 0; i < 4; i++) add(0, 0, 1, 4'h4, 0, 0, 0, 12'h089, 0, 0);
        add(0, 0, 0, 4'h2, 1, 0, 1, 12'h082, 0, 0);
        add(0, 0, 0, 4'h2, 0, 1, 0, 12'h082, 0, 0);

        #12;
        check("reset rd_valid", 32'(rd_valid), 0);
        check("reset rd_total", 32'(rd_total), 0);
        check("reset rd_sat", 32'(rd_sat), 0);
        check("reset sat", 32'(sat), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].vld, vecs[i].ovf, vecs[i].out,
                  vecs[i].req, vecs[i].rdy);
            step();
            check($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d rd_total", i), 32'(rd_total), 32'(vecs[i].e_total));
            check($sformatf("vec%0d rd_sat", i), 32'(rd_sat), 32'(vecs[i].e_rsat));
            check($sformatf("vec%0d sat", i), 32'(sat), 32'(vecs[i].e_sat));
        end

        // T4 saturation: clear, 255 wraps reach 0xFF, the 256th saturates
        drive(1, 0, 0, 4'h0, 0, 0);
        step();
        drive(0, 1, 1, 4'h0, 0, 0);
        repeat (255) step();
        check("sat before 256th wrap", 32'(sat), 0);
        step();
        check("sat after 256th wrap", 32'(sat), 1);
        drive(0, 0, 0, 4'hA, 1, 0);
        step();
        check("sat snap rd_valid", 32'(rd_valid), 1);
        check("sat snap rd_total", 32'(rd_total), 32'h0FFA);
        check("sat snap rd_sat", 32'(rd_sat), 1);
        // clear while the snapshot is held: live flag drops, snapshot untouched
        drive(1, 0, 0, 4'hA, 0, 0);
        step();
        check("clr sat", 32'(sat), 0);
        check("clr held rd_total", 32'(rd_total), 32'h0FFA);
        check("clr held rd_sat", 32'(rd_sat), 1);
        check("clr held rd_valid", 32'(rd_valid), 1);
        drive(0, 0, 0, 4'h3, 1, 1);
        step();
        check("post-clr rd_total", 32'(rd_total), 32'h0003);
        check("post-clr rd_sat", 32'(rd_sat), 0);
        check("post-clr rd_valid", 32'(rd_valid), 1);

        // saturate again while VALID is held, then reset mid-handshake (T1)
        drive(0, 1, 1, 4'h3, 0, 0);
        repeat (256) step();
        check("resat sat", 32'(sat), 1);
        check("resat held rd_total", 32'(rd_total), 32'h0003);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset rd_valid", 32'(rd_valid), 0);
        check("async reset rd_total", 32'(rd_total), 0);
        check("async reset rd_sat", 32'(rd_sat), 0);
        check("async reset sat", 32'(sat), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
